// File: rtl/umi_arbiter.sv
// Round-robin arbiter funnelling N UMI requesters into one registered output slot.
// Define UMI_ARB_ADDRCHECK_EN to drop packets whose dstaddr falls outside the cfg window.
module umi_arbiter #(
  parameter int N  = 4,
  parameter int UW = 256,
  parameter int AW = 64
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [N-1:0]         umi_in_valid,
  input  logic [N*UW-1:0]      umi_in_packet,
  output logic [N-1:0]         umi_in_ready,
  output logic                 umi_out_valid,
  output logic [UW-1:0]        umi_out_packet,
  input  logic                 umi_out_ready,
  input  logic [AW-1:0]        cfg_base,
  input  logic [AW-1:0]        cfg_mask,
  output logic                 err_valid,
  output logic [$clog2(N)-1:0] err_src,
  output logic [7:0]           err_count
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] ptr_next;
  logic          found;
  logic          slot_free;
  logic          xfer;
  logic          load;
  logic          drop;
  logic [UW-1:0] grant_packet;

  // First asserted valid at or after ptr, wrapping modulo N.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int j = 0; j < N; j++) begin
      if (!found && umi_in_valid[(int'(ptr) + j) % N]) begin
        found     = 1'b1;
        grant_idx = PW'((int'(ptr) + j) % N);
      end
    end
  end

  assign slot_free    = !umi_out_valid | umi_out_ready;
  assign xfer         = nreset & slot_free & found;
  assign grant_packet = umi_in_packet[int'(grant_idx)*UW +: UW];
  assign ptr_next     = (int'(grant_idx) == N-1) ? '0 : grant_idx + 1'b1;

  always_comb begin
    umi_in_ready = '0;
    if (xfer) umi_in_ready[grant_idx] = 1'b1;
  end

`ifdef UMI_ARB_ADDRCHECK_EN
  logic [AW-1:0] dstaddr;

  // UMI layout: dstaddr sits directly above the 32-bit command word.
  assign dstaddr = grant_packet[32 +: AW];
  assign drop    = xfer & ((dstaddr & cfg_mask) != (cfg_base & cfg_mask));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      err_valid <= 1'b0;
      err_src   <= '0;
      err_count <= 8'd0;
    end else begin
      err_valid <= drop;
      if (drop) err_src <= grant_idx;
      if (drop && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^{cfg_base, cfg_mask};
  assign drop       = 1'b0;
  assign err_valid  = 1'b0;
  assign err_src    = '0;
  assign err_count  = 8'd0;
`endif

  assign load = xfer & !drop;

  // Dropped packets still advance ptr so a misbehaving requester cannot stall the rotation.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ptr            <= '0;
      umi_out_valid  <= 1'b0;
      umi_out_packet <= '0;
    end else begin
      if (xfer) ptr <= ptr_next;
      if (load) begin
        umi_out_valid  <= 1'b1;
        umi_out_packet <= grant_packet;
      end else if (umi_out_ready) begin
        umi_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_umi_arbiter.sv
// Self-checking bench for umi_arbiter: vector table plus hand sequences, packets tracked by a scoreboard.
// Works with or without UMI_ARB_ADDRCHECK_EN defined.
module tb_umi_arbiter;

  localparam int N  = 4;
  localparam int UW = 256;
  localparam int AW = 64;
`ifdef UMI_ARB_ADDRCHECK_EN
  localparam bit ADDRCHECK = 1'b1;
`else
  localparam bit ADDRCHECK = 1'b0;
`endif

  logic            clk;
  logic            nreset;
  logic [N-1:0]    umi_in_valid;
  logic [N*UW-1:0] umi_in_packet;
  logic [N-1:0]    umi_in_ready;
  logic            umi_out_valid;
  logic [UW-1:0]   umi_out_packet;
  logic            umi_out_ready;
  logic [AW-1:0]   cfg_base;
  logic [AW-1:0]   cfg_mask;
  logic            err_valid;
  logic [1:0]      err_src;
  logic [7:0]      err_count;

  umi_arbiter #(.N(N), .UW(UW), .AW(AW)) dut (
    .clk            (clk),
    .nreset         (nreset),
    .umi_in_valid   (umi_in_valid),
    .umi_in_packet  (umi_in_packet),
    .umi_in_ready   (umi_in_ready),
    .umi_out_valid  (umi_out_valid),
    .umi_out_packet (umi_out_packet),
    .umi_out_ready  (umi_out_ready),
    .cfg_base       (cfg_base),
    .cfg_mask       (cfg_mask),
    .err_valid      (err_valid),
    .err_src        (err_src),
    .err_count      (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] valid;
    logic         out_ready;
    logic [N-1:0] exp_ready;
    logic         exp_out_valid;
  } vec_t;

  int            checks = 0;
  int            failures = 0;
  logic [UW-1:0] sb[$];
  int            sent[N];
  logic [AW-1:0] dst_addr[N];
  logic          exp_err_valid = 1'b0;
  logic [1:0]    exp_err_src = '0;
  logic [7:0]    model_count = 8'd0;
  vec_t          vecs[22];

  function automatic logic [UW-1:0] make_pkt(input int idx, input int seq, input logic [AW-1:0] dst);
    logic [UW-1:0] p;
    for (int k = 0; k < UW/32; k++) p[k*32 +: 32] = {8'(k), 8'(idx), 16'(seq)};
    p[32 +: AW] = dst;
    return p;
  endfunction

  task automatic check(input string name, input logic [UW-1:0] act, input logic [UW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge; each requester offers its next packet.
  task automatic applyStimulus(input logic [N-1:0] v, input logic ordy);
    @(negedge clk);
    umi_in_valid  = v;
    umi_out_ready = ordy;
    for (int i = 0; i < N; i++) umi_in_packet[i*UW +: UW] = make_pkt(i, sent[i], dst_addr[i]);
    #1;
  endtask

  // Compare outputs, then account for what the coming rising edge should do.
  task automatic checkOutput(input string name, input logic [N-1:0] exp_ready,
                             input logic exp_ov, input logic drop);
    check({name, ".ready"}, UW'(umi_in_ready), UW'(exp_ready));
    check({name, ".out_valid"}, UW'(umi_out_valid), UW'(exp_ov));
    check({name, ".err_valid"}, UW'(err_valid), UW'(exp_err_valid));
    check({name, ".err_count"}, UW'(err_count), UW'(model_count));
    if (exp_err_valid) check({name, ".err_src"}, UW'(err_src), UW'(exp_err_src));
    if (umi_out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL %s.sb_empty actual=out_valid required=no_packet", name);
      end else begin
        check({name, ".packet"}, umi_out_packet, sb[0]);
        if (umi_out_ready) void'(sb.pop_front());
      end
    end
    exp_err_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (exp_ready[i] && umi_in_valid[i]) begin
        if (drop) begin
          exp_err_valid = 1'b1;
          exp_err_src   = 2'(i);
          if (model_count != 8'hFF) model_count = model_count + 8'd1;
        end else begin
          sb.push_back(make_pkt(i, sent[i], dst_addr[i]));
        end
        sent[i]++;
      end
    end
  endtask

  task automatic step(input string name, input logic [N-1:0] v, input logic ordy,
                      input logic [N-1:0] exp_ready, input logic exp_ov, input logic drop);
    applyStimulus(v, ordy);
    checkOutput(name, exp_ready, exp_ov, drop);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Round-robin walk from ptr=0, idle holds, lone requester, sparse 1/3, stalls.
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1};
    vecs[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b1};
    vecs[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b0};
    vecs[7]  = '{4'b0001, 1'b1, 4'b0001, 1'b0};
    vecs[8]  = '{4'b1010, 1'b1, 4'b0010, 1'b1};
    vecs[9]  = '{4'b1010, 1'b1, 4'b1000, 1'b1};
    vecs[10] = '{4'b1010, 1'b1, 4'b0010, 1'b1};
    vecs[11] = '{4'b0100, 1'b0, 4'b0000, 1'b1};
    vecs[12] = '{4'b0100, 1'b0, 4'b0000, 1'b1};
    vecs[13] = '{4'b0100, 1'b1, 4'b0100, 1'b1};
    vecs[14] = '{4'b0000, 1'b0, 4'b0000, 1'b1};
    vecs[15] = '{4'b0000, 1'b1, 4'b0000, 1'b1};
    vecs[16] = '{4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[17] = '{4'b1000, 1'b0, 4'b1000, 1'b0};
    vecs[18] = '{4'b0001, 1'b0, 4'b0000, 1'b1};
    vecs[19] = '{4'b0001, 1'b1, 4'b0001, 1'b1};
    vecs[20] = '{4'b0000, 1'b1, 4'b0000, 1'b1};
    vecs[21] = '{4'b0000, 1'b1, 4'b0000, 1'b0};

    for (int i = 0; i < N; i++) begin
      sent[i]     = 0;
      dst_addr[i] = '0;
    end
    nreset        = 1'b0;
    umi_in_valid  = '0;
    umi_in_packet = '0;
    umi_out_ready = 1'b0;
    cfg_base      = '0;
    cfg_mask      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.out_valid", UW'(umi_out_valid), '0);
    check("reset.packet", umi_out_packet, '0);
    check("reset.err_count", UW'(err_count), '0);
    nreset = 1'b1;

    for (int r = 0; r < 22; r++) begin
      step($sformatf("vec%0d", r), vecs[r].valid, vecs[r].out_ready,
           vecs[r].exp_ready, vecs[r].exp_out_valid, 1'b0);
    end

    // Five stalled cycles, then the next in rotation loads as the held packet drains.
    step("bp_load", 4'b1111, 1'b1, 4'b0010, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step($sformatf("bp_stall%0d", k), 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b0);
    step("bp_release", 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b0);
    step("bp_drain", 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0);

    // Reset mid-traffic: slot discarded, ready forced low, rotation restarts at 0.
    step("rst_pre", 4'b1111, 1'b0, 4'b1000, 1'b0, 1'b0);
    @(negedge clk);
    nreset = 1'b0;
    #1;
    check("rst_mid.out_valid", UW'(umi_out_valid), '0);
    check("rst_mid.packet", umi_out_packet, '0);
    check("rst_mid.ready", UW'(umi_in_ready), '0);
    check("rst_mid.err_valid", UW'(err_valid), '0);
    check("rst_mid.err_src", UW'(err_src), '0);
    sb.delete();
    exp_err_valid = 1'b0;
    model_count   = 8'd0;
    @(negedge clk);
    check("rst_hold.ready", UW'(umi_in_ready), '0);
    umi_in_valid = '0;
    nreset       = 1'b1;
    step("rst_first", 4'b0110, 1'b1, 4'b0010, 1'b0, 1'b0);
    step("rst_out", 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0);
    step("rst_idle", 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);

    // Address window 0x1000/0xFFFF_F000: 0x2000 is outside, 0x1ABC inside.
    cfg_base    = 64'h1000;
    cfg_mask    = 64'hFFFF_F000;
    dst_addr[2] = 64'h2000;
    step("addr_out", 4'b0100, 1'b1, 4'b0100, 1'b0, ADDRCHECK);
    step("addr_out_next", 4'b0000, 1'b1, 4'b0000, !ADDRCHECK, 1'b0);
    dst_addr[2] = 64'h1ABC;
    step("addr_in", 4'b0100, 1'b1, 4'b0100, 1'b0, 1'b0);
    step("addr_in_next", 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0);
    step("addr_idle", 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);

    // 300 out-of-window packets back to back: saturate the counter or forward them all.
    dst_addr[2] = 64'h2000;
    for (int k = 0; k < 300; k++) begin
      step($sformatf("sat%0d", k), 4'b0100, 1'b1, 4'b0100, ADDRCHECK ? 1'b0 : (k > 0), ADDRCHECK);
    end
    step("sat_drain", 4'b0000, 1'b1, 4'b0000, !ADDRCHECK, 1'b0);
    step("sat_idle", 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);
    check("sat_final.err_count", UW'(err_count), ADDRCHECK ? UW'(255) : '0);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL sb_leftover actual=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
